// File: rtl/mem_resp.sv
// mem_resp: memory-side responder for the I/D request arbiter channel.
// Accepts one line request per enabled cycle (no backpressure), keeps a
// line-addressed backing store and returns a tagged response exactly LATENCY
// cycles after the request cycle.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_mem_addr      request byte address (offset and upper bits ignored)
//   i_mem_data      write line data
//   i_mem_enable    request valid, accepted every cycle it is high
//   i_mem_write     1 = write, 0 = read
//   i_mem_id        request tag, echoed on the response
//   o_resp_valid    one-cycle response pulse per request
//   o_resp_id       tag of the answered request (0 when idle)
//   o_resp_data     read data (0 for write acks and when idle)
//   o_resp_write    1 = write ack, 0 = read data (0 when idle)
//   o_outstanding   accepted requests not yet responded to

package const_pkg;
  localparam int PA_WIDTH   = 32;
  localparam int LINE_BYTES = 16;
  localparam int ID_WIDTH   = 4;
endpackage

module mem_resp
  import const_pkg::*;
#(
  parameter int MEM_LINES = 256,
  parameter int LATENCY   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PA_WIDTH-1:0]            i_mem_addr,
  input  logic [LINE_BYTES*8-1:0]        i_mem_data,
  input  logic                           i_mem_enable,
  input  logic                           i_mem_write,
  input  logic [ID_WIDTH-1:0]            i_mem_id,
  output logic                           o_resp_valid,
  output logic [ID_WIDTH-1:0]            o_resp_id,
  output logic [LINE_BYTES*8-1:0]        o_resp_data,
  output logic                           o_resp_write,
  output logic [$clog2(LATENCY+1)-1:0]   o_outstanding
);

  localparam int LINE_W = LINE_BYTES * 8;
  localparam int OFF    = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(MEM_LINES);
  localparam int OUT_W  = $clog2(LATENCY + 1);

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic                wr;
    logic [LINE_W-1:0]   data;
  } ent_t;

  logic [LINE_W-1:0]       r_mem [MEM_LINES];
  logic [LATENCY-1:0]      r_vld_pipe;
  ent_t [LATENCY-1:0]      r_ent_pipe;
  logic [OUT_W-1:0]        r_outstanding;
  logic [OUT_W-1:0]        w_out_nxt;
  logic [IDX_W-1:0]        w_idx;
  ent_t                    w_ent_in;
  logic                    w_acc;
  logic                    w_ret;
  logic                    w_unused;

  // Offset bits and bits above the store size alias away by design.
  assign w_idx    = i_mem_addr[OFF +: IDX_W];
  assign w_unused = ^{i_mem_addr[OFF-1:0], i_mem_addr[PA_WIDTH-1:OFF+IDX_W]};

  assign w_acc = i_mem_enable & ~rst;
  assign w_ret = r_vld_pipe[LATENCY-1];

  // Read data is taken from the store as it stands before the accept edge.
  always_comb begin
    w_ent_in.id   = i_mem_id;
    w_ent_in.wr   = i_mem_write;
    w_ent_in.data = i_mem_write ? '0 : r_mem[w_idx];
  end

  // Backing store: not reset, survives rst.
  always_ff @(posedge clk) begin
    if (w_acc && i_mem_write) r_mem[w_idx] <= i_mem_data;
  end

  // Response pipeline: stage 0 loads at the accept edge, stage LATENCY-1
  // drives the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_ent_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= i_mem_enable;
      r_ent_pipe[0] <= w_ent_in;
      for (int s = 1; s < LATENCY; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        r_ent_pipe[s] <= r_ent_pipe[s-1];
      end
    end
  end

  // The presented response retires on the edge that ends its valid cycle,
  // so the count tops out at LATENCY without saturation.
  always_comb begin
    w_out_nxt = r_outstanding;
    case ({w_acc, w_ret})
      2'b10:   w_out_nxt = r_outstanding + OUT_W'(1);
      2'b01:   w_out_nxt = r_outstanding - OUT_W'(1);
      default: w_out_nxt = r_outstanding;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_outstanding <= '0;
    else     r_outstanding <= w_out_nxt;
  end

  // Response fields are forced to zero in idle cycles rather than held.
  assign o_resp_valid  = r_vld_pipe[LATENCY-1];
  assign o_resp_id     = o_resp_valid ? r_ent_pipe[LATENCY-1].id   : '0;
  assign o_resp_write  = o_resp_valid ? r_ent_pipe[LATENCY-1].wr   : 1'b0;
  assign o_resp_data   = o_resp_valid ? r_ent_pipe[LATENCY-1].data : '0;
  assign o_outstanding = r_outstanding;

endmodule

// File: tb/tb_mem_resp.sv
// tb_mem_resp: self-checking bench for mem_resp (LATENCY=4, MEM_LINES=256).
// A queue-based reference model predicts every response cycle; directed
// tables and short sequences add hand-derived expectations.
module tb_mem_resp;
  import const_pkg::*;

  localparam int LAT   = 4;
  localparam int LINES = 256;
  localparam int LW    = LINE_BYTES * 8;
  localparam int OW    = $clog2(LAT + 1);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [PA_WIDTH-1:0] i_mem_addr = '0;
  logic [LW-1:0]       i_mem_data = '0;
  logic                i_mem_enable = 1'b0;
  logic                i_mem_write = 1'b0;
  logic [ID_WIDTH-1:0] i_mem_id = '0;
  logic                o_resp_valid;
  logic [ID_WIDTH-1:0] o_resp_id;
  logic [LW-1:0]       o_resp_data;
  logic                o_resp_write;
  logic [OW-1:0]       o_outstanding;

  mem_resp #(.MEM_LINES(LINES), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_mem_addr(i_mem_addr), .i_mem_data(i_mem_data),
    .i_mem_enable(i_mem_enable), .i_mem_write(i_mem_write), .i_mem_id(i_mem_id),
    .o_resp_valid(o_resp_valid), .o_resp_id(o_resp_id), .o_resp_data(o_resp_data),
    .o_resp_write(o_resp_write), .o_outstanding(o_outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                  due;
    logic [ID_WIDTH-1:0] id;
    logic                wr;
    logic [LW-1:0]       data;
  } exp_t;

  typedef struct {
    logic en, wr; int line; logic [LW-1:0] data; logic [ID_WIDTH-1:0] id;
    logic ev; logic [ID_WIDTH-1:0] eid; logic ew; logic [LW-1:0] edata; int eout;
  } vec_t;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            ecnt  = 0;
  logic [LW-1:0] mdl_mem [LINES];
  exp_t          q[$];
  vec_t          tbl[$];

  function automatic int line_of(input logic [PA_WIDTH-1:0] a);
    return int'((a / LINE_BYTES) % LINES);
  endfunction

  function automatic logic [PA_WIDTH-1:0] la(input int line);
    return PA_WIDTH'(line * LINE_BYTES);
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic vec_t mk(input logic en, wr, input int line, input logic [LW-1:0] data,
                              input logic [ID_WIDTH-1:0] id, input logic ev,
                              input logic [ID_WIDTH-1:0] eid, input logic ew,
                              input logic [LW-1:0] edata, input int eout);
    vec_t v;
    v.en = en; v.wr = wr; v.line = line; v.data = data; v.id = id;
    v.ev = ev; v.eid = eid; v.ew = ew; v.edata = edata; v.eout = eout;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (edge %0d)", nm, act, req, ecnt);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check outputs #1 later.
  task automatic step(input logic r, input logic en, input logic wr,
                      input logic [PA_WIDTH-1:0] addr, input logic [LW-1:0] data,
                      input logic [ID_WIDTH-1:0] id);
    exp_t e;
    int   li;
    rst = r; i_mem_enable = en; i_mem_write = wr;
    i_mem_addr = addr; i_mem_data = data; i_mem_id = id;
    @(posedge clk);
    ecnt++;
    if (r) q.delete();
    else if (en) begin
      li     = line_of(addr);
      e.due  = ecnt + LAT - 1;
      e.id   = id;
      e.wr   = wr;
      e.data = wr ? '0 : mdl_mem[li];
      if (wr) mdl_mem[li] = data;
      q.push_back(e);
    end
    #1;
    chk("model_outstanding", LW'(o_outstanding), LW'(q.size()));
    n_cmp++;
    if (o_outstanding > OW'(LAT)) begin
      n_bad++;
      $display("FAIL outstanding_range: actual=%0d limit=%0d", o_outstanding, LAT);
    end
    if (q.size() > 0 && q[0].due == ecnt) begin
      e = q.pop_front();
      chk("model_valid", LW'(o_resp_valid), LW'(1));
      chk("model_id",    LW'(o_resp_id),    LW'(e.id));
      chk("model_write", LW'(o_resp_write), LW'(e.wr));
      chk("model_data",  o_resp_data,       e.data);
    end else begin
      chk("model_valid_idle", LW'(o_resp_valid), '0);
      chk("model_fields_idle", LW'({o_resp_id, o_resp_write}) | o_resp_data, '0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic run_tbl(input string nm);
    foreach (tbl[i]) begin
      step(1'b0, tbl[i].en, tbl[i].wr, la(tbl[i].line), tbl[i].data, tbl[i].id);
      chk({nm, "_valid"}, LW'(o_resp_valid),  LW'(tbl[i].ev));
      chk({nm, "_id"},    LW'(o_resp_id),     LW'(tbl[i].eid));
      chk({nm, "_write"}, LW'(o_resp_write),  LW'(tbl[i].ew));
      chk({nm, "_data"},  o_resp_data,        tbl[i].edata);
      chk({nm, "_outst"}, LW'(o_outstanding), LW'(tbl[i].eout));
    end
    tbl.delete();
  endtask

  initial begin
    logic [LW-1:0] a5, x, y, z;
    int acc, ret;
    a5 = {LINE_BYTES{8'hA5}};
    foreach (mdl_mem[i]) mdl_mem[i] = '0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, '0, '0, '0);
    step(1'b1, 1'b1, 1'b1, la(1), rnd_line(), 4'd3);
    chk("reset_valid", LW'(o_resp_valid), '0);
    chk("reset_outst", LW'(o_outstanding), '0);
    chk("reset_data",  o_resp_data, '0);

    // Fill every line with its own index so later reads are well defined.
    for (int i = 0; i < LINES; i++) step(1'b0, 1'b1, 1'b1, la(i), LW'(i), ID_WIDTH'(i));
    idle(LAT);

    // Back-to-back stream of 8 reads, lines 0..7
    for (int k = 0; k < 12; k++) begin
      acc = (k + 1 < 8) ? k + 1 : 8;
      ret = (k >= 4) ? ((k - 3 < 8) ? k - 3 : 8) : 0;
      tbl.push_back(mk(k < 8, 1'b0, k, '0, ID_WIDTH'(k),
                       (k >= 3 && k <= 10), ID_WIDTH'((k >= 3 && k <= 10) ? k - 3 : 0), 1'b0,
                       LW'((k >= 3 && k <= 10) ? k - 3 : 0), acc - ret));
    end
    run_tbl("stream");

    // Single write then read of line 5
    tbl.push_back(mk(1, 1, 5, a5, 4'd0, 0, 4'd0, 0, '0, 1));
    tbl.push_back(mk(1, 0, 5, '0, 4'd1, 0, 4'd0, 0, '0, 2));
    tbl.push_back(mk(0, 0, 0, '0, 4'd0, 0, 4'd0, 0, '0, 2));
    tbl.push_back(mk(0, 0, 0, '0, 4'd0, 1, 4'd0, 1, '0, 2));
    tbl.push_back(mk(0, 0, 0, '0, 4'd0, 1, 4'd1, 0, a5, 1));
    tbl.push_back(mk(0, 0, 0, '0, 4'd0, 0, 4'd0, 0, '0, 0));
    run_tbl("wr_rd");

    // Bubbles: requests in cycles 0, 2, 3
    tbl.push_back(mk(1, 0, 9,  '0, 4'd9,  0, 4'd0,  0, '0,      1));
    tbl.push_back(mk(0, 0, 0,  '0, 4'd0,  0, 4'd0,  0, '0,      1));
    tbl.push_back(mk(1, 0, 10, '0, 4'd10, 0, 4'd0,  0, '0,      2));
    tbl.push_back(mk(1, 0, 11, '0, 4'd11, 1, 4'd9,  0, LW'(9),  3));
    tbl.push_back(mk(0, 0, 0,  '0, 4'd0,  0, 4'd0,  0, '0,      2));
    tbl.push_back(mk(0, 0, 0,  '0, 4'd0,  1, 4'd10, 0, LW'(10), 2));
    tbl.push_back(mk(0, 0, 0,  '0, 4'd0,  1, 4'd11, 0, LW'(11), 1));
    tbl.push_back(mk(0, 0, 0,  '0, 4'd0,  0, 4'd0,  0, '0,      0));
    run_tbl("bubble");

    // Aliasing: offset bits and upper bits are ignored
    x = rnd_line();
    step(1'b0, 1'b1, 1'b1, PA_WIDTH'(3 * LINE_BYTES + 7), x, 4'd2);
    step(1'b0, 1'b1, 1'b0, PA_WIDTH'((LINES + 3) * LINE_BYTES), '0, 4'd5);
    idle(2);
    idle(1);
    chk("alias_valid", LW'(o_resp_valid), LW'(1));
    chk("alias_data",  o_resp_data, x);
    idle(1);

    // Reset mid-flight: two writes accepted, third request lands on reset
    y = rnd_line(); z = rnd_line();
    step(1'b0, 1'b1, 1'b1, la(50), y, 4'd1);
    step(1'b0, 1'b1, 1'b1, la(51), z, 4'd2);
    step(1'b1, 1'b1, 1'b1, la(52), rnd_line(), 4'd3);
    chk("rst_outst", LW'(o_outstanding), '0);
    for (int i = 0; i < 6; i++) begin
      idle(1);
      chk("rst_no_pulse", LW'(o_resp_valid), '0);
    end
    step(1'b0, 1'b1, 1'b0, la(50), '0, 4'd4);
    step(1'b0, 1'b1, 1'b0, la(51), '0, 4'd5);
    step(1'b0, 1'b1, 1'b0, la(52), '0, 4'd6);
    idle(1);
    chk("rst_kept_w50", o_resp_data, y);
    idle(1);
    chk("rst_kept_w51", o_resp_data, z);
    idle(1);
    chk("rst_dropped_w52", o_resp_data, LW'(52));
    idle(1);

    // Idle with garbage on the ungated inputs
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'($urandom), $urandom, rnd_line(), ID_WIDTH'($urandom));
      chk("idle_outst", LW'(o_outstanding), '0);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, la(i * 37), '0, ID_WIDTH'(i));
    idle(LAT);

    // Random traffic against the model, with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7), 1'($urandom),
           $urandom, rnd_line(), ID_WIDTH'($urandom));
    end
    idle(LAT + 1);
    chk("final_outst", LW'(o_outstanding), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_resp.md
Name: mem_resp

Overview:
- Memory-side responder for the request channel driven by the instruction/data request arbiter (addr, data, enable, write, id).
- Accepts one line-sized request per cycle with no backpressure and holds a line-addressed backing store.
- Returns a tagged response a fixed LATENCY cycles after acceptance. The response carries the request id, so the requester can route it back to the I- or D-side.

Parameters:
- MEM_LINES, 256, number of LINE_BYTES-wide lines in the backing store; power of two, >= 2.
- LATENCY, 4, cycles from request acceptance to response valid; >= 1.
- PA_WIDTH, LINE_BYTES and ID_WIDTH are taken from const_pkg; they are not module parameters.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- i_mem_addr  input  PA_WIDTH  request byte address
- i_mem_data  input  LINE_BYTES*8  write line data
- i_mem_enable  input  1  request valid; accepted every cycle it is high
- i_mem_write  input  1  1 = write, 0 = read
- i_mem_id  input  ID_WIDTH  request tag
- o_resp_valid  output  1  response valid, one-cycle pulse per request
- o_resp_id  output  ID_WIDTH  tag of the request being answered
- o_resp_data  output  LINE_BYTES*8  read data; zero for write responses
- o_resp_write  output  1  1 = write acknowledge, 0 = read data
- o_outstanding  output  $clog2(LATENCY+1)  number of accepted requests not yet responded to

Behaviour:
- Clock and reset: clk is the only clock. rst is synchronous and active-high.
- Reset values: o_resp_valid=0, o_resp_id=0, o_resp_data=0, o_resp_write=0, o_outstanding=0. All pipeline valid bits are cleared.
- Reset does not touch the backing store. In simulation the store starts at all-zero.
- Line index: idx = i_mem_addr[OFF +: $clog2(MEM_LINES)], where OFF = $clog2(LINE_BYTES).
  - Byte-offset bits are ignored.
  - Upper address bits are ignored, so addresses alias modulo MEM_LINES*LINE_BYTES.
- Acceptance: on a rising edge with i_mem_enable=1 and rst=0 the request is accepted. There is no ready signal; every enabled cycle is one request.
- Write:
  - mem[idx] <= i_mem_data at the accept edge.
  - The entry enters the pipeline with write=1 and data=0.
- Read:
  - Data is sampled from mem[idx] as it stands before the accept edge.
  - A write accepted in the same cycle is impossible, since there is one request per cycle.
  - A write accepted in an earlier cycle is visible to the read.
- Pipeline:
  - LATENCY-stage shift register of {valid, id, write, data}.
  - An entry accepted at edge N appears on the o_resp_* outputs after edge N+LATENCY-1 and is valid during the cycle following that edge. That is exactly LATENCY cycles after the request cycle.
  - Back-to-back requests produce back-to-back responses in issue order, with no reordering, merging or dropping.
- Idle outputs: when o_resp_valid=0, o_resp_id, o_resp_data and o_resp_write are driven to 0, not held.
- o_outstanding:
  - +1 on an accept edge.
  - -1 on an edge where the response currently presented is retired, i.e. o_resp_valid=1 in that cycle.
  - Both in the same cycle: unchanged.
  - It never exceeds LATENCY, with no saturation logic needed. Asserting overflow or underflow is a bench check.
- Reset mid-operation:
  - In-flight responses are discarded and no response pulses for them.
  - o_outstanding goes to 0.
  - Writes already accepted remain in the store.
  - A request presented in the reset cycle is ignored, with no store update.
- ID handling: the id is passed through unchanged and not checked for uniqueness. Duplicate ids are answered as issued.
- Ungated inputs: i_mem_write and i_mem_data are don't-care when i_mem_enable=0.

Test Plan (LATENCY=4, MEM_LINES=256):
1. Single write then read: write addr line 5, data pattern A5…A5, id 0; read line 5, id 1, next cycle.
   - Required: write ack (valid=1, write=1, id 0, data 0) 4 cycles after the write.
   - Required: read response (write=0, id 1, data A5…A5) the following cycle.
2. Back-to-back stream: 8 consecutive reads of lines 0..7 (pre-written with value = line index), ids 0..7.
   - Required: 8 consecutive valid cycles starting 4 cycles after the first request, ids 0..7 in order, data 0..7.
   - Required: o_outstanding ramps 1,2,3,4 and holds at 4 during the stream, then falls to 0.
3. Aliasing: write line 3 via byte address 3*LINE_BYTES+7, then read via address (256+3)*LINE_BYTES.
   - Required: read returns the written data.
4. Reset mid-flight: issue 3 requests, assert rst for 1 cycle 2 cycles after the first request.
   - Required: no o_resp_valid pulses for those requests, o_outstanding=0 after reset.
   - Required: a later read of any write accepted before reset returns the new data.
5. Bubbles: requests at cycles 0, 2, 3 with ids 9, 10, 11.
   - Required: responses at cycles 4, 6, 7 with ids 9, 10, 11.
   - Required: o_resp_valid=0 and all response fields 0 at cycle 5.
6. Idle: i_mem_enable=0 with random addr/data/write for 20 cycles.
   - Required: no responses, store unchanged, o_outstanding stays 0.
